// File: rtl/ascii_lane_splitter_if.sv
// rtl/ascii_lane_splitter_if.sv - byte stream in / classified character lanes out
//
// Purpose : groups the source handshake and the classified output lanes of
//           ascii_lane_splitter into one bundle.
// Signals : in_data/in_valid/in_ready - source byte handshake
//           out_en                    - downstream emit permission
//           cap_flow/low_flow         - uppercase / lowercase lanes
//           other_flag                - emitted byte is not a letter
//           flow_valid                - lanes carry a character this cycle
// Modports: master - source/downstream side, slave - the splitter itself.
interface ascii_lane_splitter_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       out_en;
   logic [7:0] cap_flow;
   logic [7:0] low_flow;
   logic       other_flag;
   logic       flow_valid;

   modport master (
      output in_data, in_valid, out_en,
      input  in_ready, cap_flow, low_flow, other_flag, flow_valid
   );

   modport slave (
      input  in_data, in_valid, out_en,
      output in_ready, cap_flow, low_flow, other_flag, flow_valid
   );
endinterface

// File: rtl/ascii_lane_splitter.sv
// rtl/ascii_lane_splitter.sv - FIFO-buffered ASCII byte classifier with per-class counters
//
// Purpose : buffers an ASCII byte stream in a DEPTH-entry FIFO and emits one
//           byte per permitted cycle on an uppercase or lowercase lane, flagging
//           non-letters; keeps saturating per-class statistics.
// Ports   : clk       - system clock, rising edge
//           rst_n     - asynchronous active-low reset
//           clr       - synchronous flush of FIFO and lanes (counters kept)
//           bus       - ascii_lane_splitter_if.slave (input handshake + lanes)
//           cap_cnt   - uppercase bytes emitted since reset (saturating)
//           low_cnt   - lowercase bytes emitted since reset (saturating)
//           other_cnt - non-letter bytes emitted since reset (saturating)
module ascii_lane_splitter #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int CW    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   ascii_lane_splitter_if.slave  bus,
   output logic [CW-1:0]         cap_cnt,
   output logic [CW-1:0]         low_cnt,
   output logic [CW-1:0]         other_cnt
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;

   logic [7:0]    cap_q, cap_d;
   logic [7:0]    low_q, low_d;
   logic          other_q, other_d;
   logic          valid_q, valid_d;

   logic [CW-1:0] cap_cnt_q, cap_cnt_d;
   logic [CW-1:0] low_cnt_q, low_cnt_d;
   logic [CW-1:0] other_cnt_q, other_cnt_d;

   logic          full;
   logic          empty;
   logic          wr_en;
   logic          rd_en;
   logic [7:0]    rd_byte;
   logic          is_upper;
   logic          is_lower;

   // Full/empty come from the registered count only, so in_ready never
   // depends on out_en: no write-through when the FIFO is full.
   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign wr_en    = bus.in_valid && !full && !clr;
   assign rd_en    = bus.out_en && !empty && !clr;
   assign rd_byte  = mem_q[rptr_q];
   assign is_upper = (rd_byte >= 8'h41) && (rd_byte <= 8'h5A);
   assign is_lower = (rd_byte >= 8'h61) && (rd_byte <= 8'h7A);

   always_comb begin
      mem_d       = mem_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      cap_cnt_d   = cap_cnt_q;
      low_cnt_d   = low_cnt_q;
      other_cnt_d = other_cnt_q;
      // Lanes are single-cycle pulses: they fall back to idle unless a read
      // reloads them on this edge.
      cap_d       = 8'h00;
      low_d       = 8'h00;
      other_d     = 1'b0;
      valid_d     = 1'b0;

      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_en) begin
            mem_d[wptr_q] = bus.in_data;
            wptr_d        = wptr_q + AW'(1);
         end
         if (rd_en) begin
            rptr_d  = rptr_q + AW'(1);
            valid_d = 1'b1;
            if (is_upper) begin
               cap_d = rd_byte;
               if (cap_cnt_q != CNT_MAX) cap_cnt_d = cap_cnt_q + CW'(1);
            end else if (is_lower) begin
               low_d = rd_byte;
               if (low_cnt_q != CNT_MAX) low_cnt_d = low_cnt_q + CW'(1);
            end else begin
               other_d = 1'b1;
               if (other_cnt_q != CNT_MAX) other_cnt_d = other_cnt_q + CW'(1);
            end
         end
         count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         cap_q       <= 8'h00;
         low_q       <= 8'h00;
         other_q     <= 1'b0;
         valid_q     <= 1'b0;
         cap_cnt_q   <= '0;
         low_cnt_q   <= '0;
         other_cnt_q <= '0;
      end else begin
         mem_q       <= mem_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         cap_q       <= cap_d;
         low_q       <= low_d;
         other_q     <= other_d;
         valid_q     <= valid_d;
         cap_cnt_q   <= cap_cnt_d;
         low_cnt_q   <= low_cnt_d;
         other_cnt_q <= other_cnt_d;
      end
   end

   assign bus.in_ready   = !full && !clr;
   assign bus.cap_flow   = cap_q;
   assign bus.low_flow   = low_q;
   assign bus.other_flag = other_q;
   assign bus.flow_valid = valid_q;
   assign cap_cnt        = cap_cnt_q;
   assign low_cnt        = low_cnt_q;
   assign other_cnt      = other_cnt_q;

endmodule

// File: tb/tb_ascii_lane_splitter.sv
// tb/tb_ascii_lane_splitter.sv - self-checking bench for ascii_lane_splitter (CW=16 and CW=4 builds)
module tb_ascii_lane_splitter;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;

   ascii_lane_splitter_if a_if ();
   ascii_lane_splitter_if b_if ();

   logic [15:0] a_cap_cnt, a_low_cnt, a_oth_cnt;
   logic [3:0]  b_cap_cnt, b_low_cnt, b_oth_cnt;

   ascii_lane_splitter #(.DEPTH(4), .AW(2), .CW(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(a_if.slave),
      .cap_cnt(a_cap_cnt), .low_cnt(a_low_cnt), .other_cnt(a_oth_cnt)
   );

   ascii_lane_splitter #(.DEPTH(4), .AW(2), .CW(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b_if.slave),
      .cap_cnt(b_cap_cnt), .low_cnt(b_low_cnt), .other_cnt(b_oth_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // reference model: queue contents, expected lanes and counters
   logic [7:0] q[$];
   logic [7:0] e_cap, e_low;
   logic       e_oth, e_val, e_ready;
   int         m_cap16, m_low16, m_oth16, m_cap4, m_low4, m_oth4;
   logic       last_accept;
   logic [1:0] obs_ready;
   logic [97:0] obs_vec, exp_vec;
   logic [95:0] zvec;

   function automatic int bump(int c, int mx);
      return (c < mx) ? c + 1 : c;
   endfunction

   task automatic model_clear();
      q.delete();
      e_cap = 8'h00; e_low = 8'h00; e_oth = 1'b0; e_val = 1'b0;
      m_cap16 = 0; m_low16 = 0; m_oth16 = 0;
      m_cap4 = 0;  m_low4 = 0;  m_oth4 = 0;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic oe, input logic c);
      a_if.in_valid = v; a_if.in_data = d; a_if.out_en = oe;
      b_if.in_valid = v; b_if.in_data = d; b_if.out_en = oe;
      clr = c;
   endtask

   // One clock: drive inputs, advance the model, sample outputs on the falling edge.
   task automatic step(input logic v, input logic [7:0] d, input logic oe, input logic c);
      logic rd, wr;
      logic [7:0] b;
      drive(v, d, oe, c);
      #1;
      obs_ready = {a_if.in_ready, b_if.in_ready};
      e_ready = (q.size() < DEPTH) && !c;
      @(posedge clk);
      e_cap = 8'h00; e_low = 8'h00; e_oth = 1'b0; e_val = 1'b0;
      last_accept = 1'b0;
      if (c) begin
         q.delete();
      end else begin
         rd = oe && (q.size() > 0);
         wr = v && (q.size() < DEPTH);
         if (rd) begin
            b = q.pop_front();
            e_val = 1'b1;
            if (b >= "A" && b <= "Z") begin
               e_cap = b; m_cap16 = bump(m_cap16, 65535); m_cap4 = bump(m_cap4, 15);
            end else if (b >= "a" && b <= "z") begin
               e_low = b; m_low16 = bump(m_low16, 65535); m_low4 = bump(m_low4, 15);
            end else begin
               e_oth = 1'b1; m_oth16 = bump(m_oth16, 65535); m_oth4 = bump(m_oth4, 15);
            end
         end
         if (wr) begin
            q.push_back(d);
            last_accept = 1'b1;
         end
      end
      @(negedge clk);
      obs_vec = {obs_ready,
                 a_if.cap_flow, a_if.low_flow, a_if.other_flag, a_if.flow_valid,
                 b_if.cap_flow, b_if.low_flow, b_if.other_flag, b_if.flow_valid,
                 a_cap_cnt, a_low_cnt, a_oth_cnt, b_cap_cnt, b_low_cnt, b_oth_cnt};
      exp_vec = {{2{e_ready}},
                 e_cap, e_low, e_oth, e_val,
                 e_cap, e_low, e_oth, e_val,
                 m_cap16[15:0], m_low16[15:0], m_oth16[15:0],
                 m_cap4[3:0], m_low4[3:0], m_oth4[3:0]};
   endtask

   task automatic do_reset();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      model_clear();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      model_clear();
      #3;
      zvec = {a_if.cap_flow, a_if.low_flow, a_if.other_flag, a_if.flow_valid,
              b_if.cap_flow, b_if.low_flow, b_if.other_flag, b_if.flow_valid,
              a_cap_cnt, a_low_cnt, a_oth_cnt, b_cap_cnt, b_low_cnt, b_oth_cnt};
      checks++;
      if (zvec !== '0) $display("FAIL reset_outputs: got %h want 0", zvec);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL reset_first_cycle: got %h want %h", obs_vec, exp_vec);
      else passed++;
   endtask

   task automatic test_love();
      logic [7:0] love  [10] = '{8'h49, 8'h20, 8'h4C, 8'h6F, 8'h76, 8'h65, 8'h20, 8'h59, 8'h6F, 8'h75};
      logic [7:0] x_cap [10] = '{8'h49, 8'h00, 8'h4C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h59, 8'h00, 8'h00};
      logic [7:0] x_low [10] = '{8'h00, 8'h00, 8'h00, 8'h6F, 8'h76, 8'h65, 8'h00, 8'h00, 8'h6F, 8'h75};
      logic [16:0] got[$];
      int first_acc = -1;
      int first_val = -1;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         if (i < 10) step(1'b1, love[i], 1'b1, 1'b0);
         else        step(1'b0, 8'h00, 1'b1, 1'b0);
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL love_cycle%0d: got %h want %h", i, obs_vec, exp_vec);
         else passed++;
         if (last_accept && first_acc < 0) first_acc = i;
         if (a_if.flow_valid) begin
            if (first_val < 0) first_val = i;
            got.push_back({a_if.cap_flow, a_if.low_flow, a_if.other_flag});
         end
      end
      checks++;
      if (first_val - first_acc != 1) $display("FAIL love_latency: got %0d edges want 2", first_val - first_acc + 1);
      else passed++;
      checks++;
      if (got.size() != 10) $display("FAIL love_count: got %0d want 10", got.size());
      else passed++;
      for (int i = 0; i < 10 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== {x_cap[i], x_low[i], (x_cap[i] == 8'h00 && x_low[i] == 8'h00)})
            $display("FAIL love_lane%0d: got %h want %h", i, got[i],
                     {x_cap[i], x_low[i], (x_cap[i] == 8'h00 && x_low[i] == 8'h00)});
         else passed++;
      end
      checks++;
      if ({a_cap_cnt, a_low_cnt, a_oth_cnt} !== {16'd3, 16'd5, 16'd2})
         $display("FAIL love_counters: got %0d/%0d/%0d want 3/5/2", a_cap_cnt, a_low_cnt, a_oth_cnt);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [7:0] bp [5];
      logic [7:0] got[$];
      int i = 0;
      do_reset();
      for (int k = 0; k < 5; k++) bp[k] = 8'(($urandom % 2) ? 8'h41 : 8'h61) + 8'($urandom % 26);
      for (int k = 0; k < 6; k++) begin
         step(1'b1, bp[i], 1'b0, 1'b0);
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL bp_fill%0d: got %h want %h", k, obs_vec, exp_vec);
         else passed++;
         if (last_accept) i++;
      end
      checks++;
      if (i != 4 || obs_ready !== 2'b00) $display("FAIL bp_full: got %0d accepts ready %b want 4 ready 00", i, obs_ready);
      else passed++;
      for (int k = 0; k < 20 && got.size() < 5; k++) begin
         step(i < 5, bp[(i < 5) ? i : 4], 1'b1, 1'b0);
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL bp_drain%0d: got %h want %h", k, obs_vec, exp_vec);
         else passed++;
         if (last_accept) i++;
         if (a_if.flow_valid) got.push_back(a_if.cap_flow | a_if.low_flow);
      end
      checks++;
      if (got.size() != 5) $display("FAIL bp_timeout: got %0d bytes want 5", got.size());
      else passed++;
      for (int k = 0; k < got.size(); k++) begin
         checks++;
         if (got[k] !== bp[k]) $display("FAIL bp_order%0d: got %h want %h", k, got[k], bp[k]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int run = 0;
      int best = 0;
      for (int i = 0; i < 24; i++) begin
         if (i < 20) step(1'b1, 8'(8'h61 + i), 1'b1, 1'b0);
         else        step(1'b0, 8'h00, 1'b1, 1'b0);
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL stream_cycle%0d: got %h want %h", i, obs_vec, exp_vec);
         else passed++;
         run = a_if.flow_valid ? run + 1 : 0;
         if (run > best) best = run;
      end
      checks++;
      if (best != 20) $display("FAIL stream_run: got %0d want 20", best);
      else passed++;
   endtask

   task automatic test_clr();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL clr_fill%0d: got %h want %h", i, obs_vec, exp_vec);
         else passed++;
      end
      step(1'b1, 8'h5A, 1'b1, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL clr_edge: got %h want %h", obs_vec, exp_vec);
      else passed++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL clr_empty: got %h want %h", obs_vec, exp_vec);
      else passed++;
      step(1'b1, 8'h62, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL clr_next: got %h want %h", obs_vec, exp_vec);
      else passed++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if ({a_cap_cnt, a_low_cnt, a_oth_cnt, a_if.flow_valid} !== {16'd0, 16'd1, 16'd0, 1'b0})
         $display("FAIL clr_alone: got %0d/%0d/%0d v%b want 0/1/0 v0", a_cap_cnt, a_low_cnt, a_oth_cnt, a_if.flow_valid);
      else passed++;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 19; i++) begin
         if (i < 17) step(1'b1, 8'(8'h41 + i), 1'b1, 1'b0);
         else        step(1'b0, 8'h00, 1'b1, 1'b0);
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL sat_cycle%0d: got %h want %h", i, obs_vec, exp_vec);
         else passed++;
      end
      checks++;
      if (b_cap_cnt !== 4'd15 || a_cap_cnt !== 16'd17)
         $display("FAIL sat_cap: got %0d/%0d want 15/17", b_cap_cnt, a_cap_cnt);
      else passed++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL mrst_pre: got %h want %h", obs_vec, exp_vec);
      else passed++;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      zvec = {a_if.cap_flow, a_if.low_flow, a_if.other_flag, a_if.flow_valid,
              b_if.cap_flow, b_if.low_flow, b_if.other_flag, b_if.flow_valid,
              a_cap_cnt, a_low_cnt, a_oth_cnt, b_cap_cnt, b_low_cnt, b_oth_cnt};
      checks++;
      if (zvec !== '0) $display("FAIL mrst_async: got %h want 0", zvec);
      else passed++;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL mrst_after%0d: got %h want %h", i, obs_vec, exp_vec);
         else passed++;
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL rand_cycle%0d: got %h want %h", i, obs_vec, exp_vec);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_love();
      test_backpressure();
      test_back_to_back();
      test_clr();
      test_saturation();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ascii_lane_splitter.md
Name: ascii_lane_splitter

Overview:
- Upstream feeder for the phrase-checker stage: accepts a raw ASCII byte stream over a valid/ready handshake and buffers it in a small FIFO.
- Classifies each byte and presents it on two 8-bit lanes, one character per cycle: cap_flow (uppercase letters) and low_flow (lowercase letters).
- Keeps saturating per-class statistics counters for debug readout.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, minimum 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).
- CW, 16, width of each statistics counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous flush of FIFO and output lanes; counters unaffected.
- in_data  input  8  ASCII byte from source.
- in_valid  input  1  in_data valid.
- in_ready  output  1  splitter can accept a byte this cycle.
- out_en  input  1  downstream permits one character to be emitted this cycle.
- cap_flow  output  8  uppercase lane (0x41..0x5A), else 0x00.
- low_flow  output  8  lowercase lane (0x61..0x7A), else 0x00.
- other_flag  output  1  emitted byte is neither upper- nor lowercase letter.
- flow_valid  output  1  lanes carry a character this cycle.
- cap_cnt  output  CW  uppercase bytes emitted since reset.
- low_cnt  output  CW  lowercase bytes emitted since reset.
- other_cnt  output  CW  non-letter bytes emitted since reset.

Behaviour:
- Reset (rst_n low, async): FIFO empty, pointers 0, count 0. Outputs: cap_flow=0x00, low_flow=0x00, other_flag=0, flow_valid=0, all counters 0. Upon release, in_ready=1 in the first cycle.
- in_ready = !full && !clr, combinational from registered count.
- Write: byte is stored when in_valid && in_ready at a clock edge.
- Read: occurs when out_en && !empty at an edge, using FIFO state before that edge. Reading pops one byte.
- Output registers load on the read edge:
  - Upper (0x41..0x5A): cap_flow=byte, low_flow=0x00, other_flag=0.
  - Lower (0x61..0x7A): low_flow=byte, cap_flow=0x00, other_flag=0.
  - Else: both lanes 0x00, other_flag=1.
  - flow_valid=1.
- Edge with no read: lanes return to 0x00, other_flag=0, flow_valid=0. Outputs are single-cycle, never held.
- Latency: byte written at edge N, FIFO previously empty, out_en high → lanes valid in the cycle after edge N+1. Minimum 2 edges.
- Throughput: one byte per cycle sustained with continuous in_valid and out_en, with no bubbles after the first fill.
- Simultaneous read and write when neither empty nor full: both occur and count is unchanged.
- Empty with a write: write only; no same-cycle bypass.
- Full: in_ready=0 even if a read occurs that cycle (no write-through at full).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and is tracked in AW+1 bits.
- clr high at an edge: FIFO empty, pointers 0, lanes 0x00, flow_valid=0. Any pending write and read that cycle are discarded. Counters retain their values.
- Counters: increment by 1 on each read of the matching class. They saturate at 2^CW−1 and never wrap.
- Reset asserted mid-stream: immediate return to reset values, with stored bytes lost.
- Bytes ≥0x80 are classed as other.

Test Plan:
- Reset then feed "I Love You" (0x49,0x20,0x4C,0x6F,0x76,0x65,0x20,0x59,0x6F,0x75) with out_en=1 → per-cycle lanes:
  - cap 0x49; other; cap 0x4C; low 0x6F,0x76,0x65; other; cap 0x59; low 0x6F,0x75.
  - First valid is 2 edges after the first accept.
  - Final counters: cap_cnt=3, low_cnt=5, other_cnt=2.
- out_en=0, push 5 bytes with DEPTH=4 → in_ready drops after 4 accepts and the 5th is held by the source. Raise out_en → the 4 stored bytes plus the 5th emerge in order, with no loss or duplication.
- Continuous in_valid and out_en for 20 bytes 0x61..0x74 → flow_valid high for 20 consecutive cycles, low_flow follows the sequence, and the pointer wraps correctly.
- Fill with 3 bytes, assert clr for 1 cycle alongside in_valid → no output, FIFO empty, following byte emerges alone, and counters are unchanged.
- Force cap_cnt near saturation (CW=4 build, 17 uppercase bytes) → cap_cnt stops at 15.
- Assert rst_n low mid-burst with 2 bytes stored → all outputs 0 asynchronously, and nothing from before reset appears afterward.
